// File: rtl/billiard_pkg.sv
// billiard_pkg: shared layer config types, config FSM states and default colours
package billiard_pkg;
  localparam int MAX_LAYERS = 8;
  typedef logic [$clog2(MAX_LAYERS)-1:0] layer_idx_t;
  typedef logic [$clog2(MAX_LAYERS)-1:0] rank_t;
  typedef struct packed {
    rank_t rank;
    logic  enable;
  } layer_cfg_t;
  typedef enum logic [1:0] {CFG_IDLE, CFG_PENDING, CFG_COMMIT} cfg_state_t;
  localparam logic [7:0] TRANSPARENT_DEF = 8'hFF;
  localparam logic [7:0] BG_COLOR_DEF = 8'h00;
endpackage

// File: rtl/layer_priority_encoder.sv
// layer_priority_encoder: candidate mask, overlap flag and lowest-rank winner search
module layer_priority_encoder
  import billiard_pkg::*;
#(
  parameter int NUM_LAYERS = 4,
  parameter int RGB_W = 8,
  parameter logic [RGB_W-1:0] TRANSPARENT = TRANSPARENT_DEF,
  localparam int LW = $clog2(NUM_LAYERS)
) (
  input  logic [NUM_LAYERS-1:0]       req,
  input  logic [NUM_LAYERS*RGB_W-1:0] rgb,
  input  layer_cfg_t                  cfg [NUM_LAYERS],
  output logic [NUM_LAYERS-1:0]       cand,
  output logic                        multi,
  output logic                        win_valid,
  output logic [LW-1:0]               win_idx,
  output logic [RGB_W-1:0]            win_rgb
);
  rank_t best;
  assign multi = (cand & (cand - 1'b1)) != '0;
  always_comb begin
    cand = '0;
    win_valid = 1'b0;
    win_idx = '0;
    win_rgb = '0;
    best = '0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      cand[i] = req[i] && cfg[i].enable && rgb[i*RGB_W +: RGB_W] != TRANSPARENT;
      if (cand[i] && (!win_valid || cfg[i].rank < best)) begin
        win_valid = 1'b1;
        best = cfg[i].rank;
        win_idx = LW'(i);
        win_rgb = rgb[i*RGB_W +: RGB_W];
      end
    end
  end
endmodule

// File: rtl/layer_priority_arbiter.sv
// layer_priority_arbiter: frame-synchronous priority mux of drawing layers onto one RGB output
module layer_priority_arbiter
  import billiard_pkg::*;
#(
  parameter int NUM_LAYERS = 4,
  parameter int RGB_W = 8,
  parameter logic [RGB_W-1:0] TRANSPARENT = TRANSPARENT_DEF,
  parameter logic [RGB_W-1:0] BG_COLOR = BG_COLOR_DEF,
  localparam int LW = $clog2(NUM_LAYERS)
) (
  input  logic                        clk,
  input  logic                        resetN,
  input  logic                        startOfFrame,
  input  logic [NUM_LAYERS-1:0]       drawingRequest,
  input  logic [NUM_LAYERS*RGB_W-1:0] RGBIn,
  input  logic                        cfgValid,
  output logic                        cfgReady,
  input  logic [LW-1:0]               cfgLayer,
  input  logic [LW-1:0]               cfgRank,
  input  logic                        cfgEnable,
  output logic                        cfgPending,
  output logic [RGB_W-1:0]            RGBOut,
  output logic                        winValid,
  output logic [LW-1:0]               winLayer,
  output logic [NUM_LAYERS-1:0]       overlapMask
);
  cfg_state_t state, nxt;
  layer_cfg_t shadow [NUM_LAYERS];
  layer_cfg_t active [NUM_LAYERS];
  layer_cfg_t eff [NUM_LAYERS];
  logic [NUM_LAYERS-1:0] cand, acc, contrib;
  logic multi, win_valid, accept;
  logic [LW-1:0] win_idx;
  logic [RGB_W-1:0] win_rgb;
  assign accept = cfgValid && cfgReady;
  assign contrib = multi ? cand : '0;
  always_ff @(posedge clk)
    state <= !resetN ? CFG_IDLE : nxt;
  always_comb
    nxt = state == CFG_IDLE ? (accept ? CFG_PENDING : CFG_IDLE) :
          state == CFG_PENDING ? (startOfFrame ? CFG_COMMIT : CFG_PENDING) : CFG_IDLE;
  always_comb begin
    cfgReady = state != CFG_COMMIT;
    cfgPending = state != CFG_IDLE;
  end
  // the commit cycle is the frame's second pixel, which must already see the new table
  always_comb
    for (int i = 0; i < NUM_LAYERS; i++) eff[i] = state == CFG_COMMIT ? shadow[i] : active[i];
  layer_priority_encoder #(
    .NUM_LAYERS(NUM_LAYERS),
    .RGB_W(RGB_W),
    .TRANSPARENT(TRANSPARENT)
  ) u_enc (
    .req(drawingRequest),
    .rgb(RGBIn),
    .cfg(eff),
    .cand(cand),
    .multi(multi),
    .win_valid(win_valid),
    .win_idx(win_idx),
    .win_rgb(win_rgb)
  );
  always_ff @(posedge clk) begin
    if (!resetN) begin
      for (int i = 0; i < NUM_LAYERS; i++) begin
        shadow[i] <= '{rank: rank_t'(i), enable: 1'b1};
        active[i] <= '{rank: rank_t'(i), enable: 1'b1};
      end
      acc <= '0;
      overlapMask <= '0;
      RGBOut <= BG_COLOR;
      winValid <= 1'b0;
      winLayer <= '0;
    end else begin
      if (accept) shadow[cfgLayer] <= '{rank: rank_t'(cfgRank), enable: cfgEnable};
      if (state == CFG_COMMIT)
        for (int i = 0; i < NUM_LAYERS; i++) active[i] <= shadow[i];
      acc <= startOfFrame ? contrib : acc | contrib;
      if (startOfFrame) overlapMask <= acc;
      RGBOut <= win_valid ? win_rgb : BG_COLOR;
      winValid <= win_valid;
      winLayer <= win_idx;
    end
  end
endmodule

// File: tb/tb_layer_priority_arbiter.sv
// tb_layer_priority_arbiter: directed and random checks against a table-level reference model
module tb_layer_priority_arbiter;
  logic clk = 1'b0;
  logic resetN, startOfFrame, cfgValid, cfgReady, cfgEnable, cfgPending, winValid;
  logic [3:0] drawingRequest, overlapMask;
  logic [31:0] RGBIn;
  logic [1:0] cfgLayer, cfgRank, winLayer;
  logic [7:0] RGBOut;
  int total = 0;
  int bad = 0;
  int sh_r[4], ac_r[4];
  bit sh_e[4], ac_e[4];
  bit m_pend, m_commit;
  bit [3:0] m_acc, e_ovl;
  bit [7:0] e_rgb;
  bit e_valid;
  int e_layer;
  always #5 clk = ~clk;
  layer_priority_arbiter dut (
    .clk(clk),
    .resetN(resetN),
    .startOfFrame(startOfFrame),
    .drawingRequest(drawingRequest),
    .RGBIn(RGBIn),
    .cfgValid(cfgValid),
    .cfgReady(cfgReady),
    .cfgLayer(cfgLayer),
    .cfgRank(cfgRank),
    .cfgEnable(cfgEnable),
    .cfgPending(cfgPending),
    .RGBOut(RGBOut),
    .winValid(winValid),
    .winLayer(winLayer),
    .overlapMask(overlapMask)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step(input bit rn, input bit sof, input bit [3:0] req, input bit [31:0] rgb,
                      input bit cv, input bit [1:0] cl, input bit [1:0] cr, input bit ce);
    int tr[4];
    bit te[4];
    bit cand[4];
    bit [3:0] contrib;
    int n, best;
    resetN = rn; startOfFrame = sof; drawingRequest = req; RGBIn = rgb;
    cfgValid = cv; cfgLayer = cl; cfgRank = cr; cfgEnable = ce;
    if (!rn) begin
      for (int i = 0; i < 4; i++) begin
        sh_r[i] = i; ac_r[i] = i; sh_e[i] = 1; ac_e[i] = 1;
      end
      m_pend = 0; m_commit = 0; m_acc = 0; e_ovl = 0; e_rgb = 0; e_valid = 0; e_layer = 0;
    end else begin
      n = 0;
      best = -1;
      for (int i = 0; i < 4; i++) begin
        tr[i] = m_commit ? sh_r[i] : ac_r[i];
        te[i] = m_commit ? sh_e[i] : ac_e[i];
        cand[i] = req[i] && te[i] && rgb[i*8 +: 8] != 8'hFF;
        n += int'(cand[i]);
      end
      for (int i = 0; i < 4; i++)
        if (cand[i] && (best < 0 || tr[i] < tr[best])) best = i;
      e_valid = best >= 0;
      e_rgb = 8'h00;
      e_layer = 0;
      if (e_valid) begin
        e_rgb = rgb[best*8 +: 8];
        e_layer = best;
      end
      for (int i = 0; i < 4; i++) contrib[i] = cand[i] && n > 1;
      if (sof) begin
        e_ovl = m_acc;
        m_acc = contrib;
      end else m_acc |= contrib;
      if (m_commit) begin
        for (int i = 0; i < 4; i++) begin
          ac_r[i] = sh_r[i]; ac_e[i] = sh_e[i];
        end
        m_commit = 0;
      end else begin
        if (cv) begin
          sh_r[cl] = cr; sh_e[cl] = ce;
        end
        if (m_pend && sof) begin
          m_commit = 1; m_pend = 0;
        end else if (cv) m_pend = 1;
      end
    end
    @(posedge clk);
    #1;
    check("rgb", RGBOut, e_rgb);
    check("valid", winValid, e_valid);
    check("layer", winLayer, e_layer);
    check("overlap", overlapMask, e_ovl);
    check("pending", cfgPending, m_pend || m_commit);
    check("ready", cfgReady, !m_commit);
  endtask
  task automatic pix(input bit sof, input bit [3:0] req, input bit [31:0] rgb);
    step(1, sof, req, rgb, 0, 0, 0, 0);
  endtask
  task automatic wr(input bit sof, input bit [1:0] cl, input bit [1:0] cr, input bit ce,
                    input bit [3:0] req, input bit [31:0] rgb);
    step(1, sof, req, rgb, 1, cl, cr, ce);
  endtask
  initial begin
    bit [31:0] rgb;
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    check("rst_rgb", RGBOut, 8'h00);
    check("rst_pending", cfgPending, 0);
    pix(0, 4'b0101, {8'h00, 8'h03, 8'h00, 8'h1C});
    check("t1_rgb", RGBOut, 8'h1C);
    check("t1_layer", winLayer, 0);
    check("t1_valid", winValid, 1);
    pix(0, 4'b0011, {8'h00, 8'h00, 8'h20, 8'hFF});
    check("t2_rgb", RGBOut, 8'h20);
    check("t2_layer", winLayer, 1);
    pix(0, 4'b0000, {8'h11, 8'h22, 8'h33, 8'h44});
    check("t2_bg", RGBOut, 8'h00);
    check("t2_novalid", winValid, 0);
    wr(0, 3, 0, 1, 4'b1001, {8'h33, 8'h00, 8'h00, 8'h11});
    check("t3_pending", cfgPending, 1);
    check("t3_old", winLayer, 0);
    wr(0, 0, 3, 1, 4'b1001, {8'h33, 8'h00, 8'h00, 8'h11});
    check("t3_old2", RGBOut, 8'h11);
    pix(1, 4'b1001, {8'h33, 8'h00, 8'h00, 8'h11});
    check("t3_first_px", winLayer, 0);
    check("t3_commit_ready", cfgReady, 0);
    pix(0, 4'b1001, {8'h33, 8'h00, 8'h00, 8'h11});
    check("t3_new", winLayer, 3);
    check("t3_ready_back", cfgReady, 1);
    check("t3_idle", cfgPending, 0);
    pix(1, 4'b0000, 32'h0);
    for (int k = 0; k < 3; k++) pix(0, 4'b0110, {8'h00, 8'h05, 8'h06, 8'h00});
    pix(1, 4'b0000, 32'h0);
    check("t5_mask", overlapMask, 4'b0110);
    pix(0, 4'b0010, {8'h00, 8'h00, 8'h07, 8'h00});
    pix(0, 4'b0000, 32'h0);
    check("t5_hold", overlapMask, 4'b0110);
    pix(1, 4'b0000, 32'h0);
    check("t5_clear", overlapMask, 4'b0000);
    wr(0, 2, 2, 1, 4'b0000, 32'h0);
    check("t4_pending", cfgPending, 1);
    wr(1, 1, 1, 0, 4'b0010, {8'h00, 8'h00, 8'h44, 8'h00});
    check("t4_first_px", winLayer, 1);
    for (int k = 0; k < 3; k++) begin
      pix(0, 4'b0010, {8'h00, 8'h00, 8'h44, 8'h00});
      check("t4_hidden", winValid, 0);
    end
    wr(0, 0, 3, 1, 4'b0000, 32'h0);
    step(0, 0, 4'b1111, 32'h01020304, 1, 1, 0, 0);
    check("t6_pending", cfgPending, 0);
    check("t6_valid", winValid, 0);
    check("t6_rgb", RGBOut, 8'h00);
    pix(0, 4'b1001, {8'h33, 8'h00, 8'h00, 8'h11});
    check("t6_default", winLayer, 0);
    pix(0, 4'b0010, {8'h00, 8'h00, 8'h44, 8'h00});
    check("t6_enabled", winLayer, 1);
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < 4; i++) rgb[i*8 +: 8] = $urandom_range(0, 3) == 0 ? 8'hFF : 8'($urandom);
      step($urandom_range(0, 199) != 0, $urandom_range(0, 15) == 0, 4'($urandom), rgb,
           $urandom_range(0, 3) == 0, 2'($urandom), 2'($urandom), $urandom_range(0, 3) != 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
